// File: rtl/brush_pkg.sv
// ---------------------------------------------------------------------------
// brush_pkg
// Shared definitions for the brush stamp point generator:
//   - slot count and core/ring split
//   - signed 3-bit (dx, dy) offset tables for the 9 core and 12 ring slots
//   - slot index type and FSM state encoding
//   - helper to sign-extend a 3-bit offset to the 16-bit coordinate width
// Optional feature macro used by the design: BRUSH_CLIP_EN.
// ---------------------------------------------------------------------------
package brush_pkg;

    localparam int BRUSH_SLOTS = 21;
    localparam int CORE_SLOTS  = 9;
    localparam int RING_SLOTS  = 12;

    typedef logic [4:0] slot_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Core 3x3, walked centre first, then clockwise starting east.
    localparam logic signed [2:0] CORE_DX [CORE_SLOTS] = '{
        3'sd0, 3'sd1, 3'sd1, 3'sd0, -3'sd1, -3'sd1, -3'sd1, 3'sd0, 3'sd1
    };
    localparam logic signed [2:0] CORE_DY [CORE_SLOTS] = '{
        3'sd0, 3'sd0, 3'sd1, 3'sd1, 3'sd1, 3'sd0, -3'sd1, -3'sd1, -3'sd1
    };

    // Radius-2 ring; entry k is the point at angle 30*k degrees.
    localparam logic signed [2:0] RING_DX [RING_SLOTS] = '{
        3'sd2, 3'sd2, 3'sd1, 3'sd0, -3'sd1, -3'sd2,
        -3'sd2, -3'sd2, -3'sd1, 3'sd0, 3'sd1, 3'sd2
    };
    localparam logic signed [2:0] RING_DY [RING_SLOTS] = '{
        3'sd0, 3'sd1, 3'sd2, 3'sd2, 3'sd2, 3'sd1,
        3'sd0, -3'sd1, -3'sd2, -3'sd2, -3'sd2, -3'sd1
    };

    function automatic logic [15:0] sext_off(input logic signed [2:0] off);
        return {{13{off[2]}}, off};
    endfunction

endpackage

// File: rtl/brush_offset_rom.sv
// ---------------------------------------------------------------------------
// brush_offset_rom
// Combinational slot decoder: maps a slot index (0..20) and the ring angle
// mask to the slot's signed (dx, dy) offset and its enable bit.
// Slots 0..8 are the always-enabled core; slot 9+k is enabled by
// angle_mask[k]. Indices 21..31 decode to a disabled zero offset.
// Ports:
//   slot        in   5  slot index
//   angle_mask  in  12  ring enable mask
//   dx, dy      out  3  signed offset
//   enable      out  1  slot is part of the footprint
// ---------------------------------------------------------------------------
module brush_offset_rom
    import brush_pkg::*;
(
    input  logic [4:0]        slot,
    input  logic [11:0]       angle_mask,
    output logic signed [2:0] dx,
    output logic signed [2:0] dy,
    output logic              enable
);

    // slot[3:0] - 9 modulo 16 gives the ring index 0..11 for slots 9..20
    // without needing the upper slot bit.
    logic [3:0] ring_k;

    always_comb begin
        ring_k = slot[3:0] - 4'd9;
        dx     = 3'sd0;
        dy     = 3'sd0;
        enable = 1'b0;
        if (slot < 5'(CORE_SLOTS)) begin
            dx     = CORE_DX[slot[3:0]];
            dy     = CORE_DY[slot[3:0]];
            enable = 1'b1;
        end else if (slot < 5'(BRUSH_SLOTS)) begin
            dx     = RING_DX[ring_k];
            dy     = RING_DY[ring_k];
            enable = angle_mask[ring_k];
        end
    end

endmodule

// File: rtl/brush_stamp_gen.sv
// ---------------------------------------------------------------------------
// brush_stamp_gen
// Walks the brush footprint around a centre (cx, cy) and emits one absolute
// pixel coordinate per pt_valid/pt_ready handshake. The footprint is the
// 3x3 core plus the radius-2 ring points selected by ANGLE_MASK.
// Optional feature macro: BRUSH_CLIP_EN -- when defined, points outside
// [0,H_MAX) x [0,V_MAX) are skipped; otherwise H_MAX/V_MAX are unused.
// Ports:
//   clock        in   1  system clock, rising edge
//   reset_n      in   1  synchronous reset, active-low
//   start_valid  in   1  stamp request
//   start_ready  out  1  idle and able to accept a request
//   cx, cy       in  16  signed centre, sampled on the start handshake
//   pt_valid     out  1  point available
//   pt_ready     in   1  consumer accepts point
//   pt_x, pt_y   out 16  signed point coordinate
//   pt_last      out  1  final point of the stamp
//   busy         out  1  stamp in progress
//   done         out  1  one-cycle pulse after the stamp completes
// ---------------------------------------------------------------------------
module brush_stamp_gen
    import brush_pkg::*;
#(
    parameter logic [11:0] ANGLE_MASK = 12'h249,
    parameter logic [15:0] H_MAX      = 16'd640,
    parameter logic [15:0] V_MAX      = 16'd480
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [15:0] cx,
    input  logic [15:0] cy,
    output logic        pt_valid,
    input  logic        pt_ready,
    output logic [15:0] pt_x,
    output logic [15:0] pt_y,
    output logic        pt_last,
    output logic        busy,
    output logic        done
);

    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_EMIT = EMIT;

    logic [0:0]  state_reg;
    logic [15:0] cx_reg;
    logic [15:0] cy_reg;
    slot_t       slot_reg;
    logic        pt_valid_reg;
    logic        pt_last_reg;
    logic [15:0] pt_x_reg;
    logic [15:0] pt_y_reg;
    logic        done_reg;

    // In IDLE the search runs on the incoming centre so the first point can
    // be registered on the start handshake itself; afterwards it runs on the
    // latched centre.
    logic [15:0] base_x;
    logic [15:0] base_y;

    assign base_x = (state_reg == S_IDLE) ? cx : cx_reg;
    assign base_y = (state_reg == S_IDLE) ? cy : cy_reg;

    logic [15:0]            slot_x [BRUSH_SLOTS];
    logic [15:0]            slot_y [BRUSH_SLOTS];
    logic [BRUSH_SLOTS-1:0] elig;
    logic [BRUSH_SLOTS-1:0] cand;

    genvar gi;
    generate
        for (gi = 0; gi < BRUSH_SLOTS; gi++) begin : g_slot
            logic signed [2:0] off_x;
            logic signed [2:0] off_y;
            logic              slot_en;

            brush_offset_rom u_rom (
                .slot       (5'(gi)),
                .angle_mask (ANGLE_MASK),
                .dx         (off_x),
                .dy         (off_y),
                .enable     (slot_en)
            );

            // Plain 16-bit add: wrap-around at the coordinate limits is intended.
            assign slot_x[gi] = base_x + sext_off(off_x);
            assign slot_y[gi] = base_y + sext_off(off_y);

`ifdef BRUSH_CLIP_EN
            assign elig[gi] = slot_en
                && ($signed(slot_x[gi]) >= 16'sd0)
                && ($signed(slot_x[gi]) <  $signed(H_MAX))
                && ($signed(slot_y[gi]) >= 16'sd0)
                && ($signed(slot_y[gi]) <  $signed(V_MAX));
`else
            assign elig[gi] = slot_en;
`endif

            // From IDLE every slot is a candidate; while emitting only slots
            // after the one currently presented.
            assign cand[gi] = elig[gi]
                && ((state_reg == S_IDLE) || (5'(gi) > slot_reg));
        end
    endgenerate

`ifndef BRUSH_CLIP_EN
    logic unused_clip_bounds;
    assign unused_clip_bounds = ^{H_MAX, V_MAX};
`endif

    // Priority search: lowest candidate is the next point; any further
    // candidate above it means that point is not the last one.
    logic        sel_found;
    logic        sel_more;
    slot_t       sel_idx;
    logic [15:0] sel_x;
    logic [15:0] sel_y;

    always_comb begin
        sel_found = 1'b0;
        sel_more  = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < BRUSH_SLOTS; i++) begin
            if (cand[i]) begin
                if (!sel_found) begin
                    sel_found = 1'b1;
                    sel_idx   = 5'(i);
                end else begin
                    sel_more = 1'b1;
                end
            end
        end
        sel_x = slot_x[sel_idx];
        sel_y = slot_y[sel_idx];
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            cx_reg       <= '0;
            cy_reg       <= '0;
            slot_reg     <= '0;
            pt_valid_reg <= 1'b0;
            pt_last_reg  <= 1'b0;
            pt_x_reg     <= '0;
            pt_y_reg     <= '0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start_valid) begin
                        cx_reg    <= cx;
                        cy_reg    <= cy;
                        state_reg <= S_EMIT;
                        if (sel_found) begin
                            pt_valid_reg <= 1'b1;
                            pt_last_reg  <= !sel_more;
                            pt_x_reg     <= sel_x;
                            pt_y_reg     <= sel_y;
                            slot_reg     <= sel_idx;
                        end else begin
                            pt_valid_reg <= 1'b0;
                            pt_last_reg  <= 1'b0;
                            slot_reg     <= '0;
                        end
                    end
                end
                S_EMIT: begin
                    if (!pt_valid_reg) begin
                        // Nothing eligible (fully clipped stamp).
                        state_reg <= S_IDLE;
                        done_reg  <= 1'b1;
                    end else if (pt_ready) begin
                        if (pt_last_reg) begin
                            pt_valid_reg <= 1'b0;
                            pt_last_reg  <= 1'b0;
                            state_reg    <= S_IDLE;
                            done_reg     <= 1'b1;
                        end else begin
                            pt_last_reg <= !sel_more;
                            pt_x_reg    <= sel_x;
                            pt_y_reg    <= sel_y;
                            slot_reg    <= sel_idx;
                        end
                    end
                end
                default: begin
                    state_reg    <= S_IDLE;
                    pt_valid_reg <= 1'b0;
                    pt_last_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign start_ready = (state_reg == S_IDLE);
    assign busy        = (state_reg == S_EMIT);
    assign pt_valid    = pt_valid_reg;
    assign pt_last     = pt_last_reg;
    assign pt_x        = pt_x_reg;
    assign pt_y        = pt_y_reg;
    assign done        = done_reg;

endmodule
